// File: rtl/aes_decrypter.sv
// Iterative AES-128 inverse cipher: key schedule into 11 round-key registers,
// one inverse round per clock, plaintext queued in a small output FIFO.

module aes_gf_inv (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
    logic [7:0] pw;
    logic [7:0] acc;
    always_comb begin
        pw  = a_i;
        acc = 8'h01;
        for (int unsigned i = 0; i < 7; i++) begin
            pw  = gmul(pw, pw);
            acc = gmul(acc, pw);
        end
        y_o = acc;
    end
endmodule

module sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    logic [7:0] inv;
    aes_gf_inv u_inv (.a_i(a_i), .y_o(inv));
    assign y_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module inv_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    logic [7:0] pre;
    assign pre = {a_i[6:0], a_i[7]} ^ {a_i[4:0], a_i[7:5]} ^ {a_i[1:0], a_i[7:2]} ^ 8'h05;
    aes_gf_inv u_inv (.a_i(pre), .y_o(y_o));
endmodule

module aes_decrypter #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] data_in,
    input  logic         valid_in,
    input  logic [127:0] key,
    input  logic         valid_key,
    input  logic         fifo_rd_en_t,
    output logic [127:0] data_out,
    output logic         valid_out,
    output logic         in_ready,
    output logic         key_ready,
    output logic         busy,
    output logic         fifo_empty,
    output logic         fifo_full,
    output logic         drop
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [1:0] S_IDLE = 2'd0, S_KEXP = 2'd1, S_ROUND = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [3:0]    kcnt_q, kcnt_d, round_q, round_d;
    logic [127:0]  blk_q, blk_d, pend_q, pend_d;
    logic          pend_v_q, pend_v_d, key_ready_q, key_ready_d, drop_q, drop_d;
    logic          valid_out_q;
    logic [127:0]  data_out_q;
    logic [127:0]  rk_q [0:10];
    logic [127:0]  mem_q [0:FIFO_DEPTH-1];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          key_cap, push, pop;
    logic [127:0]  rk_prev, rk_next, rnd_res;
    logic [7:0]    ks_in [4];
    logic [7:0]    ks_out [4];
    logic [7:0]    isb_in [16];
    logic [7:0]    isb_out [16];
    logic [7:0]    col [4];
    logic [7:0]    rcon, acc;

    function automatic logic [7:0] gb(input logic [127:0] s, input int unsigned r, input int unsigned c);
        return s[127 - 8*(4*r + c) -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // sel 0..3 selects the InvMixColumns coefficients 0e, 0b, 0d, 09
    function automatic logic [7:0] imul(input logic [7:0] a, input int unsigned sel);
        logic [7:0] x2, x4, x8;
        x2 = xt(a);
        x4 = xt(x2);
        x8 = xt(x4);
        case (sel)
            0:       return x8 ^ x4 ^ x2;
            1:       return x8 ^ x2 ^ a;
            2:       return x8 ^ x4 ^ a;
            default: return x8 ^ a;
        endcase
    endfunction

    assign rk_prev = rk_q[kcnt_q - 4'd1];

    always_comb begin
        for (int unsigned r = 0; r < 4; r++) ks_in[r] = gb(rk_prev, (r + 1) % 4, 3);
        for (int unsigned r = 0; r < 4; r++)
            for (int unsigned c = 0; c < 4; c++)
                isb_in[4*r + c] = gb(blk_q, r, (c + 4 - r) % 4);
    end

    for (genvar g = 0; g < 4; g++) begin : g_ks
        sbox u_sbox (.a_i(ks_in[g]), .y_o(ks_out[g]));
    end
    for (genvar g = 0; g < 16; g++) begin : g_isb
        inv_sbox u_isb (.a_i(isb_in[g]), .y_o(isb_out[g]));
    end

    always_comb begin
        case (kcnt_q)
            4'd1: rcon = 8'h01;  4'd2: rcon = 8'h02;  4'd3: rcon = 8'h04;
            4'd4: rcon = 8'h08;  4'd5: rcon = 8'h10;  4'd6: rcon = 8'h20;
            4'd7: rcon = 8'h40;  4'd8: rcon = 8'h80;  4'd9: rcon = 8'h1b;
            4'd10: rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
        rk_next = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            acc = gb(rk_prev, r, 0) ^ ks_out[r] ^ ((r == 0) ? rcon : 8'h00);
            rk_next[127 - 8*(4*r) -: 8] = acc;
            for (int unsigned c = 1; c < 4; c++) begin
                acc = acc ^ gb(rk_prev, r, c);
                rk_next[127 - 8*(4*r + c) -: 8] = acc;
            end
        end
    end

    // Columns are mixed after AddRoundKey, so the final round just skips the mix
    always_comb begin
        rnd_res = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++)
                col[r] = isb_out[4*r + c] ^ gb(rk_q[round_q], r, c);
            for (int unsigned r = 0; r < 4; r++) begin
                if (round_q == 4'd0) begin
                    rnd_res[127 - 8*(4*r + c) -: 8] = col[r];
                end else begin
                    rnd_res[127 - 8*(4*r + c) -: 8] =
                        imul(col[0], (4 - r) % 4) ^ imul(col[1], (5 - r) % 4) ^
                        imul(col[2], (6 - r) % 4) ^ imul(col[3], (7 - r) % 4);
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        kcnt_d      = kcnt_q;
        round_d     = round_q;
        blk_d       = blk_q;
        pend_d      = pend_q;
        pend_v_d    = pend_v_q;
        key_ready_d = key_ready_q;
        key_cap     = 1'b0;
        push        = 1'b0;
        drop_d      = (valid_in && pend_v_q) || (valid_key && state_q != S_IDLE);
        if (valid_in && !pend_v_q) begin
            pend_d   = data_in;
            pend_v_d = 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (valid_key) begin
                    key_cap     = 1'b1;
                    key_ready_d = 1'b0;
                    kcnt_d      = 4'd1;
                    state_d     = S_KEXP;
                end else if (key_ready_q && pend_v_q && !fifo_full) begin
                    blk_d    = pend_q ^ rk_q[10];
                    pend_v_d = 1'b0;
                    round_d  = 4'd9;
                    state_d  = S_ROUND;
                end
            end
            S_KEXP: begin
                kcnt_d = kcnt_q + 4'd1;
                if (kcnt_q == 4'd10) begin
                    key_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_ROUND: begin
                blk_d = rnd_res;
                if (round_q == 4'd0) begin
                    push    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    round_d = round_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pop = fifo_rd_en_t && !fifo_empty;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            kcnt_q      <= '0;
            round_q     <= '0;
            blk_q       <= '0;
            pend_q      <= '0;
            pend_v_q    <= 1'b0;
            key_ready_q <= 1'b0;
            drop_q      <= 1'b0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            for (int unsigned i = 0; i < 11; i++) rk_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            kcnt_q      <= kcnt_d;
            round_q     <= round_d;
            blk_q       <= blk_d;
            pend_q      <= pend_d;
            pend_v_q    <= pend_v_d;
            key_ready_q <= key_ready_d;
            drop_q      <= drop_d;
            cnt_q       <= cnt_d;
            valid_out_q <= pop;
            if (key_cap) rk_q[0] <= key;
            if (state_q == S_KEXP) rk_q[kcnt_q] <= rk_next;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop) begin
                data_out_q <= mem_q[rptr_q];
                rptr_q     <= rptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= rnd_res;
    end

    assign data_out   = data_out_q;
    assign valid_out  = valid_out_q;
    assign in_ready   = !pend_v_q;
    assign key_ready  = key_ready_q;
    assign busy       = (state_q == S_KEXP) || (state_q == S_ROUND);
    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == FULL_CNT);
    assign drop       = drop_q;
endmodule
